// File: rtl/exec_controller.sv
// Execution sequencer: produces the CPU advance strobe and handles run/halt,
// single-step and a one-address breakpoint, plus a saturating enable counter.
module exec_controller #(
  parameter int NORMAL_CNT     = 1_000_000,
  parameter int TURBO_CNT      = 2,
  parameter int STEP_CNT_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_run_toggle,
  input  logic                      i_step_req,
  input  logic                      i_turbo,
  input  logic                      i_bp_en,
  input  logic [7:0]                i_bp_addr,
  input  logic [7:0]                i_ip,
  output logic                      o_cpu_enable,
  output logic [1:0]                o_state,
  output logic                      o_bp_hit,
  output logic [STEP_CNT_WIDTH-1:0] o_step_count
);

  localparam int MAX_CNT = (NORMAL_CNT > TURBO_CNT) ? NORMAL_CNT : TURBO_CNT;
  localparam int CW      = $clog2(MAX_CNT);
  localparam logic [CW-1:0] NORMAL_TERM = CW'(NORMAL_CNT - 1);
  localparam logic [CW-1:0] TURBO_TERM  = CW'(TURBO_CNT - 1);

  typedef enum logic [1:0] {
    S_HALT  = 2'b00,
    S_RUN   = 2'b01,
    S_STEP  = 2'b10,
    S_BREAK = 2'b11
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [CW-1:0]             r_cnt;
  logic [CW-1:0]             w_cnt_next;
  logic                      r_skip;
  logic                      w_skip_next;
  logic                      r_cpu_enable;
  logic                      w_en_next;
  logic                      r_bp_hit;
  logic [STEP_CNT_WIDTH-1:0] r_step_count;
  logic                      w_term;
  logic                      w_bp_match;

  // Using >= lets a switch to turbo mid-count fire on the very next edge.
  assign w_term     = (r_cnt >= (i_turbo ? TURBO_TERM : NORMAL_TERM));
  assign w_bp_match = i_bp_en && (i_ip == i_bp_addr) && !r_skip;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_skip_next  = r_skip;
    w_en_next    = 1'b0;
    case (r_state)
      S_HALT: begin
        if (i_run_toggle) begin
          w_state_next = S_RUN;
          w_cnt_next   = '0;
          w_skip_next  = 1'b0;
        end else if (i_step_req) begin
          w_state_next = S_STEP;
          w_en_next    = 1'b1;
        end
      end
      S_STEP: begin
        w_state_next = S_HALT;
      end
      S_RUN: begin
        if (i_run_toggle) begin
          w_state_next = S_HALT;
          w_cnt_next   = '0;
        end else if (w_term) begin
          w_cnt_next = '0;
          if (w_bp_match) begin
            w_state_next = S_BREAK;
          end else begin
            w_en_next   = 1'b1;
            w_skip_next = 1'b0;
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_BREAK: begin
        // Resume sets the skip flag so the same address is not re-trapped at once.
        if (i_run_toggle) begin
          w_state_next = S_RUN;
          w_cnt_next   = '0;
          w_skip_next  = 1'b1;
        end else if (i_step_req) begin
          w_state_next = S_STEP;
          w_en_next    = 1'b1;
        end
      end
      default: begin
        w_state_next = S_HALT;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_HALT;
      r_cnt        <= '0;
      r_skip       <= 1'b0;
      r_cpu_enable <= 1'b0;
      r_bp_hit     <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_skip       <= w_skip_next;
      r_cpu_enable <= w_en_next;
      r_bp_hit     <= (w_state_next == S_BREAK);
      if (r_cpu_enable && (r_step_count != '1)) begin
        r_step_count <= r_step_count + STEP_CNT_WIDTH'(1);
      end
    end
  end

  assign o_cpu_enable = r_cpu_enable;
  assign o_state      = r_state;
  assign o_bp_hit     = r_bp_hit;
  assign o_step_count = r_step_count;

endmodule

// File: doc/exec_controller.md
# exec_controller

Execution sequencer for the CPU: generates the single-cycle `cpu_enable` strobe that advances the processor, and implements run/halt, single-step and one-address breakpoint control from push-button pulses. It sits between the debounced/edge-detected button and switch logic and the CPU's `enable` input, in place of a free-running enable generator. A saturating counter of issued enables is exported for the display path.

## Interface
Parameters:
- `NORMAL_CNT`, default 1_000_000: clk cycles per enable in RUN, turbo off (≥2)
- `TURBO_CNT`, default 2: clk cycles per enable in RUN, turbo on (≥2)
- `STEP_CNT_WIDTH`, default 16: width of `step_count`

Ports:
- `clk`  in  1  50 MHz system clock
- `reset`  in  1  synchronous, active-high reset
- `run_toggle`  in  1  single-cycle pulse; start/stop
- `step_req`  in  1  single-cycle pulse; execute one instruction
- `turbo`  in  1  level, debounced; selects `TURBO_CNT`
- `bp_en`  in  1  level; breakpoint armed
- `bp_addr`  in  8  breakpoint instruction address
- `ip`  in  8  current CPU instruction pointer
- `cpu_enable`  out  1  registered single-cycle advance strobe to CPU
- `state`  out  2  00 HALT, 01 RUN, 10 STEP, 11 BREAK
- `bp_hit`  out  1  high while in BREAK
- `step_count`  out  STEP_CNT_WIDTH  enables issued, saturating

## Operation
- One clock; synchronous, active-high reset.
- Reset (highest priority, any state): state HALT, `cpu_enable` 0, `bp_hit` 0, `step_count` 0, rate counter 0, skip flag 0.
- HALT:
  - `run_toggle` → RUN; counter cleared; skip flag cleared.
  - Else `step_req` → STEP.
  - `run_toggle` wins if both inputs are asserted together.
- STEP: lasts exactly one cycle. `cpu_enable` is 1 during it. Next state is HALT unconditionally. `run_toggle`/`step_req` seen in STEP are dropped. No breakpoint check.
- RUN:
  - Rate counter increments each cycle.
  - Terminal condition: counter ≥ limit−1, where limit = `turbo` ? `TURBO_CNT` : `NORMAL_CNT`. Using ≥ means a turbo switch mid-count fires on the next edge.
  - At terminal, the counter wraps to 0.
  - Priority at each edge: `run_toggle` → HALT (no strobe, counter cleared) > breakpoint > strobe.
  - Breakpoint: at terminal, if `bp_en` and `ip == bp_addr` and skip flag is 0 → BREAK, no strobe.
  - Otherwise at terminal, `cpu_enable` is 1 in the following cycle and the skip flag is cleared.
  - `step_req` is ignored in RUN.
- BREAK:
  - `bp_hit` is 1.
  - `run_toggle` → RUN with skip flag set, so the first strobe after resume is not re-trapped on the same address.
  - Else `step_req` → STEP.
  - `bp_hit` drops in the cycle the state leaves BREAK.
- `step_count` increments in every cycle `cpu_enable` is 1 and saturates at all-ones. Only reset clears it.
- `cpu_enable` is never high on two consecutive cycles. Minimum spacing is `TURBO_CNT`.

## Timing
- Every output is registered. No combinational path from inputs to outputs.
- Step: `step_req` sampled at edge N → `state` = 10 and `cpu_enable` = 1 during cycle N+1 → HALT and `cpu_enable` = 0 at N+2. `step_count` updates at edge N+2.
- Run: `run_toggle` sampled at edge N → RUN with counter = 0 in cycle N+1. Counter = limit−1 in cycle N+limit. `cpu_enable` = 1 in cycle N+limit+1. Period thereafter is exactly limit cycles.
- Breakpoint: `ip` is compared at the terminal edge. `state` = 11 and `bp_hit` = 1 from the next cycle.
- Stop: `run_toggle` at edge N in RUN → HALT in cycle N+1. No strobe in N+1 even if terminal coincided.
- Reset asserted mid-strobe: `cpu_enable` is 0 in the cycle after the reset edge.

## Test plan
- Reset: assert `reset` 2 cycles from RUN mid-count → `state` = 00, `cpu_enable` = 0, `bp_hit` = 0, `step_count` = 0; no strobes for 20 cycles.
- Step (NORMAL_CNT=4, TURBO_CNT=2): `step_req` pulse at edge 10 → `cpu_enable` high only in cycle 11, `state` = 10 in cycle 11, 00 in cycle 12, `step_count` = 1. A second `step_req` in cycle 11 → no extra strobe.
- Run/turbo:
  - `run_toggle` at edge 0 → strobes in cycles 5, 9, 13.
  - Set `turbo`=1 while counter = 3 → strobe on the next cycle, then every 2 cycles.
  - `run_toggle` → HALT, no further strobes.
- Breakpoint: `bp_en`=1, `bp_addr`=0x05, `ip` held 0x05, RUN →
  - first terminal: no strobe, `state` = 11, `bp_hit` = 1;
  - `run_toggle` → next terminal strobes, `bp_hit` = 0;
  - following terminal with `ip` still 0x05 → BREAK again.
- Simultaneous events: `run_toggle` and `step_req` together in HALT → RUN, no STEP strobe. Same pair in BREAK → RUN.
- Saturation: STEP_CNT_WIDTH=4, 20 `step_req` pulses spaced 3 cycles → `step_count` reaches 15 and stays at 15.
